// File: rtl/weight_fifo_loader_pkg.sv
//------------------------------------------------------------------------------
// weight_fifo_loader_pkg
// Array-wide weight geometry and the loader state encoding.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package weight_fifo_loader_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int FIFO_INPUTS = 4;
    localparam int FIFO_STAGES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        TAIL = ST_TAIL,
        DONE = ST_DONE
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/load_row_counter.sv
//------------------------------------------------------------------------------
// load_row_counter
// Clearable, enabled up-counter that saturates at COUNT_MAX and flags it.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_row_counter #(
    parameter int WIDTH     = 2,
    parameter int COUNT_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o    = (count_q == WIDTH'(COUNT_MAX));
    assign count_o = count_q;

    // Holding at terminal count keeps a power-of-two range from wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/weight_fifo_loader.sv
//------------------------------------------------------------------------------
// weight_fifo_loader
// Streams FIFO_STAGES weight rows from memory into the weight shift FIFO.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module weight_fifo_loader
    import weight_fifo_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = weight_fifo_loader_pkg::DATA_WIDTH,
    parameter int FIFO_INPUTS = weight_fifo_loader_pkg::FIFO_INPUTS,
    parameter int FIFO_WIDTH  = DATA_WIDTH * FIFO_INPUTS,
    parameter int FIFO_STAGES = weight_fifo_loader_pkg::FIFO_STAGES,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic                  shiftReq,
    output logic                  memRdEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [FIFO_WIDTH-1:0] memRdData,
    output logic                  fifoEn,
    output logic [FIFO_WIDTH-1:0] fifoWeight,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W = $clog2(FIFO_STAGES);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  rdValid_q;

    logic                  row_clear;
    logic                  row_en;
    logic [ROW_W-1:0]      row_cnt;
    logic                  row_tc;

    load_row_counter #(
        .WIDTH     (ROW_W),
        .COUNT_MAX (FIFO_STAGES - 1)
    ) u_row_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (row_clear),
        .en_i    (row_en),
        .count_o (row_cnt),
        .tc_o    (row_tc)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        row_clear = 1'b0;
        row_en    = 1'b0;
        memRdEn   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = baseAddr;
                    row_clear = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                memRdEn = 1'b1;
                busy    = 1'b1;
                if (row_tc) begin
                    state_d = TAIL;
                end else begin
                    row_en = 1'b1;
                end
            end
            TAIL: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address wraps modulo 2^ADDR_WIDTH by plain truncating addition.
    assign memAddr = (state_q == LOAD) ? (base_q + ADDR_WIDTH'(row_cnt)) : '0;

    // Returning read data always owns the FIFO; otherwise only idle shifts pass.
    always_comb begin
        fifoEn     = 1'b0;
        fifoWeight = '0;
        if (rdValid_q) begin
            fifoEn     = 1'b1;
            fifoWeight = memRdData;
        end else if (state_q == IDLE || state_q == DONE) begin
            fifoEn = shiftReq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            rdValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rdValid_q <= memRdEn;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_weight_fifo_loader.sv
//------------------------------------------------------------------------------
// tb_weight_fifo_loader
// Loader with behavioural memory and shift FIFO, checked against row rules.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_weight_fifo_loader;

    localparam int S  = 4;
    localparam int S2 = 2;
    localparam int AW = 8;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start, shiftReq, memRdEn, fifoEn, busy, done;
    logic [AW-1:0] baseAddr, memAddr;
    logic [FW-1:0] memRdData, fifoWeight;

    logic          start2, shiftReq2, memRdEn2, fifoEn2, busy2, done2;
    logic [AW-1:0] baseAddr2, memAddr2;
    logic [FW-1:0] memRdData2, fifoWeight2;

    logic [FW-1:0] mem   [256];
    logic [FW-1:0] fifo  [S];
    logic [FW-1:0] fifo2 [S2];

    int checks = 0;
    int errors = 0;

    weight_fifo_loader #(.FIFO_STAGES(S), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
        .shiftReq(shiftReq), .memRdEn(memRdEn), .memAddr(memAddr),
        .memRdData(memRdData), .fifoEn(fifoEn), .fifoWeight(fifoWeight),
        .busy(busy), .done(done)
    );

    weight_fifo_loader #(.FIFO_STAGES(S2), .ADDR_WIDTH(AW)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .baseAddr(baseAddr2),
        .shiftReq(shiftReq2), .memRdEn(memRdEn2), .memAddr(memAddr2),
        .memRdData(memRdData2), .fifoEn(fifoEn2), .fifoWeight(fifoWeight2),
        .busy(busy2), .done(done2)
    );

    // One-cycle-latency memories and shift FIFOs (output = last stage).
    always @(posedge clk) begin
        if (memRdEn)  memRdData  <= mem[memAddr];
        if (memRdEn2) memRdData2 <= mem[memAddr2];
        if (fifoEn) begin
            for (int i = S - 1; i > 0; i--) fifo[i] <= fifo[i-1];
            fifo[0] <= fifoWeight;
        end
        if (fifoEn2) begin
            for (int i = S2 - 1; i > 0; i--) fifo2[i] <= fifo2[i-1];
            fifo2[0] <= fifoWeight2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_replicated();
        for (int a = 0; a < 256; a++) mem[a] = {4{a[7:0]}};
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 0; shiftReq = 0; baseAddr = '0;
        start2 = 0; shiftReq2 = 0; baseAddr2 = '0;
        for (int i = 0; i < S; i++) fifo[i] = '0;
        for (int i = 0; i < S2; i++) fifo2[i] = '0;
        memRdData = '0; memRdData2 = '0;
        #12;
        checks++;
        if ({busy, done, memRdEn, fifoEn} !== 4'b0000 || memAddr !== '0 || fifoWeight !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b rd=%b en=%b addr=%h w=%h, required all zero",
                     busy, done, memRdEn, fifoEn, memAddr, fifoWeight);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || memRdEn !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rd=%b, required 0 0", busy, memRdEn);
        end
    endtask

    // Full load: noise pulses start/holds shiftReq during the load window.
    task automatic run_load(input logic [7:0] base, input bit noise, input bit with_shift);
        int fe_count = 0;
        int done_count = 0;
        logic [7:0] a;
        logic exp_rd, exp_we, exp_busy, exp_done;
        logic [7:0] exp_addr;
        logic [FW-1:0] exp_w;
        start = 1; baseAddr = base; shiftReq = with_shift;
        #1;
        if (with_shift) begin
            checks++;
            if (fifoEn !== 1'b1 || fifoWeight !== '0) begin
                errors++;
                $display("FAIL start_with_shift: en=%b w=%h, required 1 00000000", fifoEn, fifoWeight);
            end
        end
        step();
        for (int c = 1; c <= S + 3; c++) begin
            if (noise && c <= S + 1) begin
                start    = (c == 2 || c == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                shiftReq = 1'b1;
                baseAddr = 8'($urandom);
            end else begin
                start = 0; shiftReq = 0;
            end
            #1;
            exp_rd   = (c >= 1 && c <= S);
            exp_addr = exp_rd ? base + 8'(c - 1) : 8'h00;
            exp_we   = (c >= 2 && c <= S + 1);
            a        = base + 8'(c - 2);
            exp_w    = exp_we ? mem[a] : '0;
            exp_busy = (c <= S + 1);
            exp_done = (c == S + 2);
            checks++;
            if (memRdEn !== exp_rd || memAddr !== exp_addr) begin
                errors++;
                $display("FAIL read c=%0d base=%h: rd=%b addr=%h, required %b %h",
                         c, base, memRdEn, memAddr, exp_rd, exp_addr);
            end
            checks++;
            if (fifoEn !== exp_we || fifoWeight !== exp_w) begin
                errors++;
                $display("FAIL write c=%0d base=%h: en=%b w=%h, required %b %h",
                         c, base, fifoEn, fifoWeight, exp_we, exp_w);
            end
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                errors++;
                $display("FAIL status c=%0d: busy=%b done=%b, required %b %b",
                         c, busy, done, exp_busy, exp_done);
            end
            if (c <= S + 1 && fifoEn === 1'b1) fe_count++;
            if (done === 1'b1) done_count++;
            step();
        end
        checks++;
        if (fe_count != S || done_count != 1) begin
            errors++;
            $display("FAIL load_counts base=%h: fifoEn=%0d done=%0d, required %0d 1",
                     base, fe_count, done_count, S);
        end
        for (int i = 0; i < S; i++) begin
            a = base + 8'(i);
            checks++;
            if (fifo[S-1-i] !== mem[a]) begin
                errors++;
                $display("FAIL fifo_row%0d base=%h: got %h, required %h", i, base, fifo[S-1-i], mem[a]);
            end
        end
    endtask

    task automatic shift_out(input logic [7:0] base, input int k);
        logic [7:0] a;
        for (int j = 1; j <= k; j++) begin
            shiftReq = 1; step(); shiftReq = 0;
            a = base + 8'(j);
            checks++;
            if (fifo[S-1] !== mem[a]) begin
                errors++;
                $display("FAIL shift_out%0d base=%h: got %h, required %h", j, base, fifo[S-1], mem[a]);
            end
        end
    endtask

    task automatic test_basic();
        fill_replicated();
        run_load(8'h10, 0, 0);
        checks++;
        if (fifo[S-1] !== 32'h10101010) begin
            errors++;
            $display("FAIL basic_head: got %h, required 10101010", fifo[S-1]);
        end
        shift_out(8'h10, 3);
        checks++;
        if (fifo[S-1] !== 32'h13131313) begin
            errors++;
            $display("FAIL basic_tail: got %h, required 13131313", fifo[S-1]);
        end
    endtask

    task automatic test_wrap();
        run_load(8'hFE, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_load(8'h40, 1, 0);
    endtask

    task automatic test_start_with_shift();
        run_load(8'h80, 0, 1);
    endtask

    task automatic test_reset_midload();
        start = 1; baseAddr = 8'h20;
        step(); start = 0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, memRdEn, fifoEn, done} !== 4'b0000 || memAddr !== '0) begin
            errors++;
            $display("FAIL reset_midload: busy=%b rd=%b en=%b done=%b addr=%h, required all zero",
                     busy, memRdEn, fifoEn, done, memAddr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        reset = 1'b1;
        run_load(8'h30, 0, 0);
    endtask

    task automatic test_s2();
        logic exp_done, exp_we;
        start2 = 1; baseAddr2 = 8'h00;
        step(); start2 = 0;
        for (int c = 1; c <= 5; c++) begin
            exp_done = (c == 4);
            exp_we   = (c >= 2 && c <= 3);
            checks++;
            if (done2 !== exp_done || fifoEn2 !== exp_we) begin
                errors++;
                $display("FAIL s2 c=%0d: done=%b en=%b, required %b %b", c, done2, fifoEn2, exp_done, exp_we);
            end
            step();
        end
        checks++;
        if (fifo2[1] !== mem[0] || fifo2[0] !== mem[1]) begin
            errors++;
            $display("FAIL s2_fifo: got %h %h, required %h %h", fifo2[1], fifo2[0], mem[0], mem[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] base;
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        for (int n = 0; n < 8; n++) begin
            base = 8'($urandom);
            run_load(base, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            shift_out(base, $urandom_range(1, S - 1));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_start_ignored();
        test_start_with_shift();
        test_reset_midload();
        test_s2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/weight_fifo_loader.md
# weight_fifo_loader

Write-side controller for the systolic array's weight shift FIFO. On a `start` pulse it reads `FIFO_STAGES` consecutive weight rows from the weight memory and shifts each row into the FIFO input, so row 0 sits at the FIFO output when loading finishes. It then signals `done`. When idle, it forwards the array controller's shift requests to the FIFO with zero fill.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one weight
- `FIFO_INPUTS`, 4, weights per row
- `FIFO_WIDTH`, `DATA_WIDTH*FIFO_INPUTS`, row width
- `FIFO_STAGES`, 4, rows per load (≥2)
- `ADDR_WIDTH`, 8, weight-memory address width

Ports:
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low; low clears all state immediately
- `start`  input  1  load request, sampled only in IDLE
- `baseAddr`  input  ADDR_WIDTH  address of row 0, captured with `start`
- `shiftReq`  input  1  array-side request to advance the FIFO by one stage
- `memRdEn`  output  1  weight-memory read strobe
- `memAddr`  output  ADDR_WIDTH  read address
- `memRdData`  input  FIFO_WIDTH  read data, valid exactly one cycle after `memRdEn`
- `fifoEn`  output  1  drives the FIFO `en`
- `fifoWeight`  output  FIFO_WIDTH  drives the FIFO `weightIn`
- `busy`  output  1  high while a load is in progress
- `done`  output  1  one-cycle pulse when a load completes

## Operation
- States:
  - IDLE: wait for `start`; `start`=1 → captures `baseAddr`, clears the row counter, goes to LOAD.
  - LOAD: `memRdEn`=1, `memAddr`=base+row, row increments each cycle; after row `FIFO_STAGES-1` is issued → TAIL.
  - TAIL: issues no read; performs the final FIFO write → DONE.
  - DONE: `done`=1 for this cycle, `busy`=0 → IDLE.
- Write path: a registered valid bit `rdValid` follows `memRdEn` by one cycle. While `rdValid`=1: `fifoEn`=1 and `fifoWeight`=`memRdData` (combinational pass-through).
- Idle path (IDLE and DONE): `fifoEn`=`shiftReq`, `fifoWeight`=0.
- During LOAD and TAIL, `shiftReq` is ignored; the loader owns the FIFO.
- `start` outside IDLE is ignored and is not queued.
- `start` and `shiftReq` high in the same IDLE cycle: the shift happens that cycle and the start is accepted.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+row wraps silently (0xFF → 0x00).
- Row counter width is clog2(FIFO_STAGES). It must not overflow at `FIFO_STAGES`=2^n.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `memRdEn`=0, `memAddr`=0, `fifoEn`=0 (given `shiftReq`=0), `fifoWeight`=0, `rdValid`=0.
- Take `start` sampled high in IDLE at edge t0 (cycle index 0):
  - cycles 1..S: reads of base..base+S-1 (S=`FIFO_STAGES`)
  - cycles 2..S+1: FIFO writes
  - cycle S+2: `done`
  - `busy` is high in cycles 1..S+1
  - start-to-done latency is S+2 cycles; back-to-back `start` is accepted at cycle S+3 at the earliest
- Reset asserted mid-load: the load is aborted with no `done`, outputs go to reset values asynchronously, and FIFO contents are undefined.
- Deasserting reset requires no warm-up; `start` is accepted on the first edge after release.

## Structure
- Shared package/header holds `DATA_WIDTH`, `FIFO_INPUTS`, `FIFO_STAGES` (common with the weight FIFO and array) and the state encoding localparams: IDLE=0, LOAD=1, TAIL=2, DONE=3.
- One natural sub-module, `load_row_counter`: a clearable, enabled up-counter with terminal-count flag, reused later by the activation loader.
- Bench instantiates the loader with the existing weight FIFO and a behavioural one-cycle-latency memory.

## Test plan
- Reset then idle, mem[a]=replicated a, S=4, `start` with base=0x10 → reads 0x10..0x13 in cycles 1–4, `fifoEn` cycles 2–5, `done` cycle 6. FIFO output is 0x10101010, and after three `shiftReq` pulses it is 0x13131313.
- Base=0xFE, S=4 → `memAddr` sequence 0xFE, 0xFF, 0x00, 0x01; FIFO holds rows in that order.
- `start` pulsed again in cycles 2 and 5 of a load, plus `shiftReq` held high throughout → exactly one load, exactly 4 `fifoEn` cycles, one `done`.
- `start` and `shiftReq` together in IDLE → `fifoEn`=1 with `fifoWeight`=0 that cycle, load begins next cycle, final FIFO contents equal a clean load.
- `reset` pulled low in cycle 3 of a load → `busy`, `memRdEn`, `fifoEn` go to 0 immediately, no `done`. A fresh `start` after release completes normally with correct data.
- S=2 build, base=0x00 → `done` at cycle 4 and the FIFO holds rows 0x00, 0x01.
